bp_me_mem_cmd_arbiter: RTL and testbench
========================================

Name: bp_me_mem_cmd_arbiter

Overview:
- Shares one memory command/response channel (bp_mem, or the mem_cmd/mem_resp buffer pair in front of it) among num_req_p requesters, e.g. CCE and the cfg loader.
- Round-robin arbitration on commands; grant locked until the downstream handshake completes.
- Requester IDs are kept in an in-order tag FIFO; each memory response is routed back to the requester that issued the matching command.
- Outstanding commands are bounded by max_outstanding_p, which prevents the memory-full deadlock.

Parameters:
num_req_p, 2, number of requesters (>=2)
msg_width_p, 128, width of one memory message (cmd or resp)
max_outstanding_p, 4, max commands sent but not yet responded to; tag FIFO depth
lg_num_req_lp, $clog2(num_req_p), requester ID width (localparam)
cnt_width_lp, $clog2(max_outstanding_p+1), outstanding counter width (localparam)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
req_cmd_i  in  num_req_p*msg_width_p  commands; requester i occupies slice i
req_cmd_v_i  in  num_req_p  command valid per requester
req_cmd_ready_o  out  num_req_p  ready_and per requester; handshake = v & ready
mem_cmd_o  out  msg_width_p  arbitrated command
mem_cmd_v_o  out  1  command valid to memory
mem_cmd_ready_i  in  1  memory ready_and
mem_resp_i  in  msg_width_p  memory response
mem_resp_v_i  in  1  response valid
mem_resp_yumi_o  out  1  response consumed
req_resp_o  out  msg_width_p  response data, broadcast to all requesters
req_resp_v_o  out  num_req_p  one-hot response valid to the owning requester
req_resp_yumi_i  in  num_req_p  response consumed by requester
outstanding_o  out  cnt_width_lp  current count of outstanding commands

Behaviour:
- Reset (synchronous): RR pointer=0, state=IDLE, counter=0, tag FIFO empty.
- During and one cycle after reset: all ready/valid/yumi outputs 0, outstanding_o=0.
- can_issue = (counter < max_outstanding_p) & tag FIFO not full.
- IDLE state:
  - If can_issue and any req_cmd_v_i is set, grant the first valid requester at or after the RR pointer (wrapping).
  - mem_cmd_v_o=1; mem_cmd_o = slice[grant].
  - req_cmd_ready_o[grant] = mem_cmd_ready_i; all other ready bits 0.
  - Zero-cycle combinational path from request to memory.
- Handshake (mem_cmd_v_o & mem_cmd_ready_i):
  - Push grant ID into the tag FIFO; counter+1.
  - RR pointer = (grant+1) mod num_req_p, wrapping at num_req_p-1 -> 0.
  - Stay in / return to IDLE.
- No handshake while mem_cmd_v_o=1: go to LOCKED and register the grant.
- LOCKED state:
  - Grant is held; mem_cmd_o stays stable; no re-arbitration even if a higher-priority requester becomes valid.
  - Exit to IDLE on handshake.
  - Requesters must hold valid and data stable once asserted; a drop of req_cmd_v_i[grant] in LOCKED is an assertion error.
- If can_issue=0: mem_cmd_v_o=0 and all req_cmd_ready_o=0. can_issue cannot fall while LOCKED, because pushes happen only on handshake.
- Response routing:
  - head = tag FIFO head.
  - req_resp_v_o[head] = mem_resp_v_i & FIFO not empty; req_resp_o = mem_resp_i.
  - mem_resp_yumi_o = req_resp_yumi_i[head] & req_resp_v_o[head].
  - On yumi: pop FIFO; counter-1.
- Response with empty tag FIFO: no v or yumi asserted; assertion error.
- Same-cycle cmd handshake and resp yumi:
  - Counter unchanged; FIFO push and pop both occur.
  - When the FIFO is full, the same-cycle pop does not free a slot for a push (can_issue uses registered state).
- Response ordering: memory returns responses in command order; the block does not reorder.
- req_resp_yumi_i on a non-head bit is ignored.
- Reset mid-operation: LOCKED state, FIFO contents and counter are discarded; the next cycle is the reset state.

Test Plan:
- Single requester 0 issues 3 back-to-back commands with mem_cmd_ready_i=1, memory responds in order -> 3 commands out in 3 cycles; outstanding_o 1,2,3 then back to 0; responses appear only on req_resp_v_o[0].
- Both requesters valid continuously, num_req_p=2, ready=1, responses returned immediately -> grants alternate 0,1,0,1; each response routed to the matching requester.
- Requester 0 valid, mem_cmd_ready_i=0 for 4 cycles, requester 1 becomes valid at cycle 2 -> grant stays 0 and mem_cmd_o stable for all 4 cycles; the handshake goes to 0; the next grant is 1.
- Issue 4 commands with no responses (max_outstanding_p=4) -> the 5th request sees ready=0 and mem_cmd_v_o=0 until one response is consumed; it issues the cycle after the consume.
- Response consume and new command handshake in the same cycle at counter=2 -> counter stays 2; FIFO head advances correctly.
- Assert reset_i while LOCKED with 2 outstanding -> next cycle outstanding_o=0, mem_cmd_v_o=0, and a new request is granted from pointer 0.

Source files
------------

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory command/response channel among several requesters.
// Responses are steered back to their issuer through an in-order tag FIFO of requester IDs.
module bp_me_mem_cmd_arbiter #(
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned max_outstanding_p = 4,
    localparam int unsigned lg_num_req_lp    = $clog2(num_req_p),
    localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p*msg_width_p-1:0]   req_cmd_i,
    input  logic [num_req_p-1:0]               req_cmd_v_i,
    output logic [num_req_p-1:0]               req_cmd_ready_o,
    output logic [msg_width_p-1:0]             mem_cmd_o,
    output logic                               mem_cmd_v_o,
    input  logic                               mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]             mem_resp_i,
    input  logic                               mem_resp_v_i,
    output logic                               mem_resp_yumi_o,
    output logic [msg_width_p-1:0]             req_resp_o,
    output logic [num_req_p-1:0]               req_resp_v_o,
    input  logic [num_req_p-1:0]               req_resp_yumi_i,
    output logic [cnt_width_lp-1:0]            outstanding_o
);

    localparam int unsigned ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                   state;
    logic [lg_num_req_lp-1:0] grant;
    logic [lg_num_req_lp-1:0] rr_ptr;
    logic [cnt_width_lp-1:0]  count;
    logic [lg_num_req_lp-1:0] tag_mem [max_outstanding_p];
    logic [ptr_width_lp-1:0]  rd_ptr;
    logic [ptr_width_lp-1:0]  wr_ptr;
    logic                     reset_d;

    logic [msg_width_p-1:0]   cmd_arr [num_req_p];
    logic [lg_num_req_lp-1:0] rr_sel;
    logic [lg_num_req_lp-1:0] rr_idx;
    logic                     rr_found;
    logic [lg_num_req_lp-1:0] cmd_sel;
    logic                     cmd_v;
    logic                     active;
    logic                     can_issue;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     hs;
    logic                     pop;
    logic [lg_num_req_lp-1:0] head;

    for (genvar i = 0; i < num_req_p; i++) begin : g_slice
        assign cmd_arr[i] = req_cmd_i[i*msg_width_p +: msg_width_p];
    end

    function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Outputs stay quiet while reset is high and for the cycle right after it.
    assign active     = ~(reset_i | reset_d);
    assign fifo_full  = (count == cnt_width_lp'(max_outstanding_p));
    assign fifo_empty = (count == '0);
    assign can_issue  = (count < cnt_width_lp'(max_outstanding_p)) & ~fifo_full;
    assign head       = tag_mem[rd_ptr];

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        rr_sel   = rr_ptr;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            rr_idx = lg_num_req_lp'((32'(rr_ptr) + i) % num_req_p);
            if (!rr_found && req_cmd_v_i[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    always_comb begin
        if (state == LOCKED) begin
            cmd_sel = grant;
            cmd_v   = can_issue;
        end else begin
            cmd_sel = rr_sel;
            cmd_v   = can_issue & rr_found;
        end
        mem_cmd_v_o     = active & cmd_v;
        mem_cmd_o       = cmd_arr[cmd_sel];
        req_cmd_ready_o = '0;
        if (mem_cmd_v_o) begin
            req_cmd_ready_o[cmd_sel] = mem_cmd_ready_i;
        end
        hs = mem_cmd_v_o & mem_cmd_ready_i;
    end

    always_comb begin
        req_resp_v_o = '0;
        if (active & mem_resp_v_i & ~fifo_empty) begin
            req_resp_v_o[head] = 1'b1;
        end
        mem_resp_yumi_o = req_resp_v_o[head] & req_resp_yumi_i[head];
        pop             = mem_resp_yumi_o;
        req_resp_o      = mem_resp_i;
        outstanding_o   = reset_i ? '0 : count;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            reset_d <= 1'b1;
        end else begin
            reset_d <= 1'b0;
            if (hs) begin
                state  <= IDLE;
                rr_ptr <= (cmd_sel == lg_num_req_lp'(num_req_p - 1)) ? '0 : cmd_sel + lg_num_req_lp'(1);
                wr_ptr <= ptr_next(wr_ptr);
            end else if (mem_cmd_v_o) begin
                state <= LOCKED;
                grant <= cmd_sel;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({hs, pop})
                2'b10:   count <= count + cnt_width_lp'(1);
                2'b01:   count <= count - cnt_width_lp'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && hs) begin
            tag_mem[wr_ptr] <= cmd_sel;
        end
    end

    locked_hold_a: assert property (@(posedge clk_i) disable iff (reset_i)
        (state == LOCKED) |-> req_cmd_v_i[grant]);

    resp_tag_a: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_v_i |-> !fifo_empty);

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Testbench for bp_me_mem_cmd_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_bp_me_mem_cmd_arbiter;

    localparam int unsigned N    = 2;
    localparam int unsigned W    = 128;
    localparam int unsigned MAXO = 4;
    localparam int unsigned CW   = $clog2(MAXO + 1);
    localparam int unsigned BW   = 1 + W + N + N + W + 1 + CW;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] req_cmd;
    logic [N-1:0]   req_cmd_v;
    logic [N-1:0]   req_cmd_ready;
    logic [W-1:0]   mem_cmd;
    logic           mem_cmd_v;
    logic           mem_cmd_ready;
    logic [W-1:0]   mem_resp;
    logic           mem_resp_v;
    logic           mem_resp_yumi;
    logic [W-1:0]   req_resp;
    logic [N-1:0]   req_resp_v;
    logic [N-1:0]   req_resp_yumi;
    logic [CW-1:0]  outstanding;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bp_me_mem_cmd_arbiter #(
        .num_req_p(N), .msg_width_p(W), .max_outstanding_p(MAXO)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_ready_o(req_cmd_ready),
        .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
        .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
        .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_yumi_i(req_resp_yumi),
        .outstanding_o(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pointer, held grant and a queue of outstanding requester IDs.
    int m_rr         = 0;
    int m_held       = -1;
    int m_tags[$];
    bit m_prev_reset = 1'b1;

    logic          e_cmd_v;
    int            e_g;
    logic [W-1:0]  e_cmd;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_resp_v;
    logic          e_yumi;
    logic [CW-1:0] e_out;
    logic [BW-1:0] e_bundle;

    function automatic logic [W-1:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] got_bundle();
        return {mem_cmd_v, (mem_cmd_v ? mem_cmd : {W{1'b0}}), req_cmd_ready, req_resp_v,
                req_resp, mem_resp_yumi, outstanding};
    endfunction

    task automatic model_eval();
        bit act;
        int g;
        act = !reset && !m_prev_reset;
        g   = -1;
        if (m_held >= 0) begin
            g = m_held;
        end else if (m_tags.size() < MAXO) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_cmd_v[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        e_cmd_v  = act && (g >= 0);
        e_g      = g;
        e_cmd    = e_cmd_v ? req_cmd[g*W +: W] : '0;
        e_ready  = (e_cmd_v && mem_cmd_ready) ? (N'(1) << g) : '0;
        e_resp_v = '0;
        e_yumi   = 1'b0;
        if (act && mem_resp_v && m_tags.size() > 0) begin
            e_resp_v = N'(1) << m_tags[0];
            e_yumi   = req_resp_yumi[m_tags[0]];
        end
        e_out    = reset ? '0 : CW'(m_tags.size());
        e_bundle = {e_cmd_v, e_cmd, e_ready, e_resp_v, mem_resp, e_yumi, e_out};
    endtask

    task automatic model_commit();
        if (reset) begin
            m_rr = 0; m_held = -1; m_tags.delete(); m_prev_reset = 1'b1;
        end else begin
            m_prev_reset = 1'b0;
            if (e_yumi) void'(m_tags.pop_front());
            if (e_cmd_v && mem_cmd_ready) begin
                m_tags.push_back(e_g);
                m_rr   = (e_g + 1) % N;
                m_held = -1;
            end else if (e_cmd_v) begin
                m_held = e_g;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    // Clock the DUT and model, then refresh the payload of a requester whose command just went out.
    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        cyc++;
        if (e_cmd_v && mem_cmd_ready) req_cmd[e_g*W +: W] = rand_msg();
    endtask

    task automatic idle_inputs();
        req_cmd_v = '0; mem_cmd_ready = 1'b0; mem_resp_v = 1'b0; req_resp_yumi = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_cmd = {rand_msg(), rand_msg()};
        req_cmd_v = 2'b11; mem_cmd_ready = 1'b1; mem_resp_v = 1'b0; mem_resp = '0; req_resp_yumi = '0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) reset = 1'b0;
            settle();
            checks++;
            if ({mem_cmd_v, req_cmd_ready, req_resp_v, mem_resp_yumi, outstanding} !== '0) begin
                errors++;
                $display("FAIL reset_quiet k=%0d got v=%b rdy=%b rv=%b y=%b out=%0d exp all 0",
                         k, mem_cmd_v, req_cmd_ready, req_resp_v, mem_resp_yumi, outstanding);
            end
            if (k == 2) begin
                checks++;
                if (got_bundle() !== e_bundle) begin
                    errors++;
                    $display("FAIL reset_bundle got=%h exp=%h", got_bundle(), e_bundle);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_single();
        logic [W-1:0] d;
        req_cmd_v = 2'b01; mem_cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = req_cmd[W-1:0];
            settle();
            checks++;
            if ({mem_cmd_v, mem_cmd, req_cmd_ready, outstanding} !== {1'b1, d, 2'b01, CW'(k)}) begin
                errors++;
                $display("FAIL single_cmd k=%0d got v=%b rdy=%b out=%0d exp v=1 rdy=01 out=%0d",
                         k, mem_cmd_v, req_cmd_ready, outstanding, k);
            end
            checks++;
            if (got_bundle() !== e_bundle) begin
                errors++;
                $display("FAIL single_bundle got=%h exp=%h", got_bundle(), e_bundle);
            end
            advance();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            mem_resp_v = (k < 3); mem_resp = rand_msg(); req_resp_yumi = 2'b11;
            settle();
            checks++;
            if ({req_resp_v, mem_resp_yumi, outstanding} !==
                {(k < 3) ? 2'b01 : 2'b00, (k < 3), CW'(3 - k)}) begin
                errors++;
                $display("FAIL single_resp k=%0d got rv=%b y=%b out=%0d exp out=%0d",
                         k, req_resp_v, mem_resp_yumi, outstanding, 3 - k);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_alternate();
        int g0;
        g0 = m_rr;
        req_cmd_v = 2'b11; mem_cmd_ready = 1'b1; req_resp_yumi = 2'b11;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) req_cmd_v = 2'b00;
            mem_resp_v = (m_tags.size() > 0); mem_resp = rand_msg();
            settle();
            checks++;
            if ({req_cmd_ready, req_resp_v} !==
                {(k < 6) ? N'(1) << ((g0 + k) % N) : N'(0), (k > 0) ? N'(1) << ((g0 + k - 1) % N) : N'(0)}) begin
                errors++;
                $display("FAIL alternate k=%0d got rdy=%b rv=%b", k, req_cmd_ready, req_resp_v);
            end
            checks++;
            if (got_bundle() !== e_bundle) begin
                errors++;
                $display("FAIL alternate_bundle got=%h exp=%h", got_bundle(), e_bundle);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        int p, q;
        logic [W-1:0] dp;
        p = (m_rr + 1) % N; q = m_rr;
        dp = req_cmd[p*W +: W];
        for (int k = 0; k < 6; k++) begin
            req_cmd_v = '0;
            if (k < 5) req_cmd_v[p] = 1'b1;
            if (k >= 2) req_cmd_v[q] = 1'b1;
            mem_cmd_ready = (k >= 4);
            settle();
            checks++;
            if (k < 5 && {mem_cmd_v, mem_cmd, req_cmd_ready} !== {1'b1, dp, (k == 4) ? N'(1) << p : N'(0)}) begin
                errors++;
                $display("FAIL lock_hold k=%0d got v=%b rdy=%b cmd=%h exp cmd=%h", k, mem_cmd_v,
                         req_cmd_ready, mem_cmd, dp);
            end else if (k == 5 && req_cmd_ready !== N'(1) << q) begin
                errors++;
                $display("FAIL lock_next got rdy=%b exp rdy=%b", req_cmd_ready, N'(1) << q);
            end
            advance();
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            mem_resp_v = 1'b1; mem_resp = rand_msg(); req_resp_yumi = 2'b11;
            settle();
            checks++;
            if (req_resp_v !== N'(1) << ((k == 0) ? p : q)) begin
                errors++;
                $display("FAIL lock_resp k=%0d got rv=%b", k, req_resp_v);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_max_outstanding();
        req_cmd_v = 2'b01; mem_cmd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_resp_v = (k == 6); req_resp_yumi = (k == 6) ? 2'b01 : 2'b00; mem_resp = rand_msg();
            settle();
            checks++;
            if (k < 4 && {mem_cmd_v, outstanding} !== {1'b1, CW'(k)}) begin
                errors++;
                $display("FAIL max_fill k=%0d got v=%b out=%0d exp v=1 out=%0d", k, mem_cmd_v, outstanding, k);
            end else if ((k == 4 || k == 5 || k == 6) && {mem_cmd_v, req_cmd_ready, outstanding} !== {1'b0, 2'b00, CW'(4)}) begin
                errors++;
                $display("FAIL max_block k=%0d got v=%b rdy=%b out=%0d exp v=0 rdy=00 out=4",
                         k, mem_cmd_v, req_cmd_ready, outstanding);
            end else if (k == 7 && {mem_cmd_v, req_cmd_ready, outstanding} !== {1'b1, 2'b01, CW'(3)}) begin
                errors++;
                $display("FAIL max_resume got v=%b rdy=%b out=%0d exp v=1 rdy=01 out=3",
                         mem_cmd_v, req_cmd_ready, outstanding);
            end
            checks++;
            if (got_bundle() !== e_bundle) begin
                errors++;
                $display("FAIL max_bundle k=%0d got=%h exp=%h", k, got_bundle(), e_bundle);
            end
            advance();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            mem_resp_v = 1'b1; req_resp_yumi = 2'b01; mem_resp = rand_msg();
            settle();
            checks++;
            if ({mem_resp_yumi, outstanding} !== {1'b1, CW'(4 - k)}) begin
                errors++;
                $display("FAIL max_drain k=%0d got y=%b out=%0d exp y=1 out=%0d", k, mem_resp_yumi, outstanding, 4 - k);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        mem_cmd_ready = 1'b1;
        req_cmd_v = 2'b01; settle(); advance();
        req_cmd_v = 2'b10; settle(); advance();
        req_cmd_v = 2'b01; mem_resp_v = 1'b1; req_resp_yumi = 2'b01; mem_resp = rand_msg();
        settle();
        checks++;
        if ({req_cmd_ready, req_resp_v, mem_resp_yumi, outstanding} !== {2'b01, 2'b01, 1'b1, CW'(2)}) begin
            errors++;
            $display("FAIL same_cycle got rdy=%b rv=%b y=%b out=%0d exp 01 01 1 2",
                     req_cmd_ready, req_resp_v, mem_resp_yumi, outstanding);
        end
        advance();
        req_cmd_v = 2'b00; req_resp_yumi = 2'b11; mem_resp = rand_msg();
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if ({req_resp_v, mem_resp_yumi, outstanding} !== {(k == 0) ? 2'b10 : 2'b01, 1'b1, CW'(2 - k)}) begin
                errors++;
                $display("FAIL same_head k=%0d got rv=%b y=%b out=%0d", k, req_resp_v, mem_resp_yumi, outstanding);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        req_cmd_v = 2'b10; mem_cmd_ready = 1'b1;
        settle(); advance();
        settle(); advance();
        mem_cmd_ready = 1'b0;
        settle();
        checks++;
        if ({mem_cmd_v, outstanding} !== {1'b1, CW'(2)}) begin
            errors++;
            $display("FAIL mid_pre got v=%b out=%0d exp v=1 out=2", mem_cmd_v, outstanding);
        end
        advance();
        reset = 1'b1; settle(); advance();
        reset = 1'b0; req_cmd_v = 2'b11; mem_cmd_ready = 1'b1;
        settle();
        checks++;
        if ({mem_cmd_v, req_cmd_ready, outstanding} !== {1'b0, 2'b00, CW'(0)}) begin
            errors++;
            $display("FAIL mid_post got v=%b rdy=%b out=%0d exp v=0 rdy=00 out=0", mem_cmd_v, req_cmd_ready, outstanding);
        end
        advance();
        settle();
        checks++;
        if ({mem_cmd_v, req_cmd_ready, outstanding} !== {1'b1, 2'b01, CW'(0)}) begin
            errors++;
            $display("FAIL mid_regrant got v=%b rdy=%b out=%0d exp v=1 rdy=01 out=0", mem_cmd_v, req_cmd_ready, outstanding);
        end
        advance();
        idle_inputs();
        mem_resp_v = 1'b1; req_resp_yumi = 2'b01; settle(); advance();
        idle_inputs();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_cmd_v[i] && $urandom_range(1, 0) == 1) req_cmd_v[i] = 1'b1;
            end
            mem_cmd_ready = ($urandom_range(3, 0) != 0);
            mem_resp_v    = (m_tags.size() > 0) && ($urandom_range(1, 0) == 1);
            mem_resp      = rand_msg();
            req_resp_yumi = N'($urandom_range(3, 0));
            settle();
            checks++;
            if (got_bundle() !== e_bundle) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random k=%0d got=%h exp=%h", k, got_bundle(), e_bundle);
            end
            advance();
            if (e_cmd_v && mem_cmd_ready) req_cmd_v[e_g] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_max_outstanding();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
